stopwatch_lap: RTL and testbench
================================

Name: stopwatch_lap

Overview:
Parametrised multi-digit BCD stopwatch with start/stop toggle, lap (split) freeze, clear, overflow flag and a multiplexed common-anode 7-segment driver. It is the successor to the fixed 4-digit stopwatch: digit count, timebase and scan rate are parameters, and lap/clear/overflow are new. It sits between the debounced push-button pulses and the board's 7-segment display.

Parameters:
NUM_DIGITS, 4, displayed digits, legal 4..8
TICK_DIV, 500000, clock cycles per 0.01 s count tick (50 MHz clock)
SCAN_DIV, 50000, clock cycles each digit is enabled during display scan

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; toggles running
lap  input  1  single-cycle pulse; freezes or releases the displayed value
clear  input  1  single-cycle pulse; zeroes the count
a,b,c,d,e,f,g  output  1 each  segment drives, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit enables, active-low, one-hot-low
running  output  1  high while counting
lap_active  output  1  high while the display is frozen
overflow  output  1  one-cycle pulse on wrap to zero
time_bcd  output  4*NUM_DIGITS  live count, digit 0 in [3:0]

Behaviour:
- Digit radices, LSB first: d0 hundredths 0-9, d1 tenths 0-9, d2 s 0-9, d3 10 s 0-5, d4 min 0-9, d5 10 min 0-5, d6 h 0-9, d7 10 h 0-9.
- Carry ripples combinationally within one tick; all digits update on the same edge.
- Reset (synchronous, active-high, priority over everything): count=0, lap register=0, prescaler=0, running=0, lap_active=0, overflow=0, scan counter/index=0.
- Reset output state: an=all ones except an[0]=0; segments show '0' (a-f=0, g=1); dp=1.
- start pulse: running toggles on that edge.
- Prescaler: counts 0..TICK_DIV-1 only while running.
  - On the edge where it is TICK_DIV-1, it wraps to 0 and the count increments.
  - First increment occurs TICK_DIV cycles after running goes high.
  - Stop holds the prescaler value, so resume keeps the partial tick.
- Overflow: a tick with every digit at its maximum (59.99 for 4 digits) wraps the count to all zeros and pulses overflow high for exactly one cycle. running stays 1.
- clear pulse: zeroes count, prescaler and lap_active. running is unchanged. clear beats a same-cycle tick (count=0, no overflow).
- clear together with start: both take effect (count zeroed, running toggled).
- lap pulse:
  - while lap_active=0 and running=1: lap register <= current count (pre-increment value if a tick coincides); lap_active=1.
  - while lap_active=1 (running or not): lap_active=0.
  - while lap_active=0 and running=0: ignored.
- Display source: lap register if lap_active, else live count. time_bcd is always the live count.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of running and reset only by reset.
  - On wrap, the digit index advances mod NUM_DIGITS.
  - an, segments and dp are registered, one cycle behind the index.
  - No leading-zero blanking.
- dp is low only when digit 2 or digit 4 is enabled (s.hh and min:s separators).
- Segment map, a..g order: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.

Test Plan:
(Bench parameters: NUM_DIGITS=4, TICK_DIV=4, SCAN_DIV=2.)
1. Reset, then start pulse, then run 400 cycles -> time_bcd=16'h0100, running=1, overflow never asserted.
2. Start; stop after 10 ticks plus 2 cycles; wait 50 cycles -> time_bcd holds 16'h0010. Restart -> next increment exactly 2 cycles after running rises.
3. Run to 16'h5999, then one more tick -> time_bcd=16'h0000, overflow high exactly one cycle, running stays 1.
4. Lap pulse at time_bcd=16'h0025 -> lap_active=1; scan shows 5,2,0,0 while time_bcd keeps advancing. Second lap pulse -> lap_active=0 and the display tracks the live count.
5. Scan check -> an cycles 1110, 1101, 1011, 0111, each held 2 cycles; dp=0 only while an=1011. Digit 0 of count 0 drives a..g=0000001.
6. Reset asserted mid-run at 16'h0342 with lap_active=1 -> next edge: all reset values. clear+start in the same cycle while stopped -> count 0 and running=1.

Source files
------------

// File: rtl/stopwatch_lap.sv
// Multi-digit BCD stopwatch with lap freeze, clear, overflow pulse and a
// multiplexed common-anode 7-segment driver. All outputs are registered.
module stopwatch_lap #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 500000,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    lap,
   input  logic                    clear,
   output logic                    a,
   output logic                    b,
   output logic                    c,
   output logic                    d,
   output logic                    e,
   output logic                    f,
   output logic                    g,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    running,
   output logic                    lap_active,
   output logic                    overflow,
   output logic [4*NUM_DIGITS-1:0] time_bcd
);

   localparam int CW = 4 * NUM_DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]    SEG_ZERO   = 7'b0000001;

   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         lap_q, lap_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic                  running_q, running_d;
   logic                  lap_active_q, lap_active_d;
   logic                  overflow_q, overflow_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic [CW-1:0] count_inc;
   logic          all_max;
   logic          tick;
   logic [CW-1:0] disp_src;
   logic [3:0]    disp_digit;

   // Largest value each digit position can hold (tens of seconds/minutes wrap at 5)
   function automatic logic [3:0] digit_max(input int pos);
      logic [3:0] m;
      case (pos)
         3, 5:    m = 4'd5;
         default: m = 4'd9;
      endcase
      return m;
   endfunction

   // Active-low segment pattern, a in bit 6 down to g in bit 0
   function automatic logic [6:0] seg_decode(input logic [3:0] val);
      logic [6:0] s;
      case (val)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Ripple-carry increment across all digits within a single tick
   always_comb begin
      logic       carry;
      logic [3:0] dig;
      count_inc = count_q;
      all_max   = 1'b1;
      carry     = 1'b1;
      dig       = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         dig = count_q[4*i +: 4];
         if (dig != digit_max(i)) all_max = 1'b0;
         if (carry) begin
            if (dig == digit_max(i)) begin
               count_inc[4*i +: 4] = 4'd0;
            end else begin
               count_inc[4*i +: 4] = dig + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   // Prescaler, count, run/lap control; clear overrides a coincident tick
   always_comb begin
      tick         = running_q && (presc_q == PRESC_LAST);
      presc_d      = presc_q;
      count_d      = count_q;
      overflow_d   = 1'b0;
      lap_d        = lap_q;
      lap_active_d = lap_active_q;
      running_d    = running_q ^ start;

      if (running_q) presc_d = tick ? '0 : presc_q + 1'b1;

      if (tick) begin
         count_d    = count_inc;
         overflow_d = all_max;
      end

      if (lap) begin
         if (lap_active_q) begin
            lap_active_d = 1'b0;
         end else if (running_q) begin
            lap_d        = count_q;
            lap_active_d = 1'b1;
         end
      end

      if (clear) begin
         count_d      = '0;
         presc_d      = '0;
         overflow_d   = 1'b0;
         lap_active_d = 1'b0;
      end
   end

   // Free-running digit scan; display outputs lag the index by one register
   always_comb begin
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         scan_d = scan_q + 1'b1;
         idx_d  = idx_q;
      end
      disp_src   = lap_active_q ? lap_q : count_q;
      disp_digit = disp_src[{idx_q, 2'b00} +: 4];
      an_d       = ~(NUM_DIGITS'(1) << idx_q);
      seg_d      = seg_decode(disp_digit);
      dp_d       = !((32'(idx_q) == 32'd2) || (32'(idx_q) == 32'd4));
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q      <= '0;
         lap_q        <= '0;
         presc_q      <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
         scan_q       <= '0;
         idx_q        <= '0;
         an_q         <= ~NUM_DIGITS'(1);
         seg_q        <= SEG_ZERO;
         dp_q         <= 1'b1;
      end else begin
         count_q      <= count_d;
         lap_q        <= lap_d;
         presc_q      <= presc_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
         overflow_q   <= overflow_d;
         scan_q       <= scan_d;
         idx_q        <= idx_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign overflow   = overflow_q;
   assign time_bcd   = count_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: integer-hundredths reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_stopwatch_lap;

   localparam int N  = 4;
   localparam int TD = 4;
   localparam int SD = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic lap   = 1'b0;
   logic clear = 1'b0;
   logic a, b, c, d, e, f, g, dp;
   logic [N-1:0]   an;
   logic           running, lap_active, overflow;
   logic [4*N-1:0] time_bcd;

   stopwatch_lap #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .clock(clock), .reset(reset), .start(start), .lap(lap), .clear(clear),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
      .an(an), .running(running), .lap_active(lap_active),
      .overflow(overflow), .time_bcd(time_bcd)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int radix [8] = '{10, 10, 10, 6, 10, 6, 10, 10};
   logic [6:0] segtab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

   function automatic int digit_of(input int v, input int pos);
      int w = 1;
      for (int i = 0; i < pos; i++) w = w * radix[i];
      return (v / w) % radix[pos];
   endfunction

   function automatic logic [4*N-1:0] to_bcd(input int v);
      logic [4*N-1:0] r = '0;
      for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(digit_of(v, i));
      return r;
   endfunction

   function automatic int modulus();
      int m = 1;
      for (int i = 0; i < N; i++) m = m * radix[i];
      return m;
   endfunction

   int m_cnt, m_presc, m_lapval, m_scan, m_idx;
   bit m_run, m_lapact, m_ovf, m_valid;
   logic [N-1:0] m_an;
   logic [6:0]   m_seg;
   bit           m_dp;

   always @(posedge clock) begin
      if (reset) begin
         m_cnt = 0; m_presc = 0; m_lapval = 0; m_scan = 0; m_idx = 0;
         m_run = 0; m_lapact = 0; m_ovf = 0;
         m_an = ~N'(1); m_seg = segtab[0]; m_dp = 1;
         m_valid = 1;
      end else if (m_valid) begin
         int  shown, nxt;
         bit  tick;
         shown = m_lapact ? m_lapval : m_cnt;
         m_an  = ~(N'(1) << m_idx);
         m_seg = segtab[digit_of(shown, m_idx)];
         m_dp  = !(m_idx == 2 || m_idx == 4);

         tick  = m_run && (m_presc == TD - 1);
         nxt   = m_cnt;
         m_ovf = 0;
         if (tick) begin
            nxt   = (m_cnt + 1) % modulus();
            m_ovf = (m_cnt + 1 == modulus());
         end
         if (m_run) m_presc = tick ? 0 : m_presc + 1;
         if (lap) begin
            if (m_lapact) m_lapact = 0;
            else if (m_run) begin m_lapval = m_cnt; m_lapact = 1; end
         end
         if (clear) begin
            nxt = 0; m_presc = 0; m_ovf = 0; m_lapact = 0;
         end
         m_cnt = nxt;
         if (start) m_run = !m_run;
         if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % N;
         end else begin
            m_scan = m_scan + 1;
         end
      end
   end

   // Compare every cycle once the model has seen a reset
   always @(negedge clock) begin
      if (m_valid) begin
         check("time_bcd",   32'(time_bcd),          32'(to_bcd(m_cnt)));
         check("running",    32'(running),           32'(m_run));
         check("lap_active", 32'(lap_active),        32'(m_lapact));
         check("overflow",   32'(overflow),          32'(m_ovf));
         check("an",         32'(an),                32'(m_an));
         check("segments",   32'({a,b,c,d,e,f,g}),   32'(m_seg));
         check("dp",         32'(dp),                32'(m_dp));
      end
   end

   bit ovf_seen = 0;
   always @(negedge clock) if (overflow === 1'b1) ovf_seen = 1;

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; cycles(1); reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; cycles(1); start = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1; cycles(1); lap = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_time"},  32'(time_bcd),        32'h0000);
      check({tag, "_run"},   32'(running),         32'd0);
      check({tag, "_lap"},   32'(lap_active),      32'd0);
      check({tag, "_ovf"},   32'(overflow),        32'd0);
      check({tag, "_an"},    32'(an),              32'b1110);
      check({tag, "_seg"},   32'({a,b,c,d,e,f,g}), 32'b0000001);
      check({tag, "_dp"},    32'(dp),              32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] an_seq [8] = '{4'b1101, 4'b1101, 4'b1011, 4'b1011,
                                 4'b0111, 4'b0111, 4'b1110, 4'b1110};
      cycles(2);

      // Scan order and reset display
      do_reset();
      check_reset_state("rst0");
      cycles(3);
      for (int i = 0; i < 8; i++) begin
         check("scan_an",  32'(an), 32'(an_seq[i]));
         check("scan_dp",  32'(dp), (an_seq[i] == 4'b1011) ? 32'd0 : 32'd1);
         check("scan_seg", 32'({a,b,c,d,e,f,g}), 32'b0000001);
         cycles(1);
      end

      // 400 cycles of running gives 1.00 s, no overflow
      do_reset();
      ovf_seen = 0;
      pulse_start();
      cycles(400);
      check("run400_time", 32'(time_bcd), 32'h0100);
      check("run400_run",  32'(running),  32'd1);
      check("run400_ovf",  32'(ovf_seen), 32'd0);

      // Stop keeps the partial tick; resume finishes it two cycles later
      do_reset();
      pulse_start();
      cycles(41);
      pulse_start();
      cycles(50);
      check("stop_hold", 32'(time_bcd), 32'h0010);
      check("stop_run",  32'(running),  32'd0);
      pulse_start();
      check("resume_t0", 32'(time_bcd), 32'h0010);
      cycles(1);
      check("resume_t1", 32'(time_bcd), 32'h0010);
      cycles(1);
      check("resume_t2", 32'(time_bcd), 32'h0011);

      // Full wrap at 59.99
      do_reset();
      pulse_start();
      cycles(23996);
      check("pre_wrap",     32'(time_bcd), 32'h5999);
      check("pre_wrap_ovf", 32'(overflow), 32'd0);
      cycles(4);
      check("wrap_time", 32'(time_bcd), 32'h0000);
      check("wrap_ovf",  32'(overflow), 32'd1);
      check("wrap_run",  32'(running),  32'd1);
      cycles(1);
      check("wrap_ovf_end", 32'(overflow), 32'd0);

      // Lap freeze at 00.25 while the live count moves on
      do_reset();
      pulse_start();
      cycles(100);
      check("lap_at", 32'(time_bcd), 32'h0025);
      pulse_lap();
      check("lap_on", 32'(lap_active), 32'd1);
      cycles(19);
      check("lap_live", 32'(time_bcd), 32'h0030);
      for (int i = 0; i < 8; i++) begin
         logic [6:0] want;
         case (an)
            4'b1110: want = 7'b0100100;
            4'b1101: want = 7'b0010010;
            default: want = 7'b0000001;
         endcase
         check("lap_seg", 32'({a,b,c,d,e,f,g}), 32'(want));
         cycles(1);
      end
      pulse_lap();
      check("lap_off", 32'(lap_active), 32'd0);

      // Reset mid-run with lap active, then clear+start together
      do_reset();
      pulse_start();
      cycles(399);
      pulse_lap();
      cycles(968);
      check("mid_time", 32'(time_bcd),   32'h0342);
      check("mid_lap",  32'(lap_active), 32'd1);
      do_reset();
      check_reset_state("rst1");
      pulse_start();
      cycles(20);
      pulse_start();
      check("stopped5", 32'(time_bcd), 32'h0005);
      clear = 1'b1; start = 1'b1;
      cycles(1);
      clear = 1'b0; start = 1'b0;
      check("clrstart_time", 32'(time_bcd), 32'h0000);
      check("clrstart_run",  32'(running),  32'd1);

      // Randomized pulses checked by the model
      for (int i = 0; i < 6000; i++) begin
         start = ($urandom_range(0, 99) < 2);
         lap   = ($urandom_range(0, 99) < 3);
         clear = ($urandom_range(0, 999) < 3);
         reset = ($urandom_range(0, 1999) < 1);
         cycles(1);
      end
      start = 1'b0; lap = 1'b0; clear = 1'b0; reset = 1'b0;
      cycles(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
